// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared types and helpers for the rr_arb_mux round-robin
//               arbiter. Provides the arbiter state encoding and a clog2
//               variant that never returns zero, so that index widths stay
//               legal for every channel count.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

    // ARB    : each beat is arbitrated independently.
    // LOCKED : a multi-beat packet owns the output (only reachable when
    //          RR_ARB_MUX_LOCK_EN is defined).
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Index width for n items, clamped to at least one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : rr_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotated first-one search. Starting at index
//               ptr and wrapping modulo N_CH, the first set bit of req wins.
//               Every output has a complete default, so all input
//               combinations are defined and no storage is implied.
// Ports       : req   [N_CH] in  - request vector
//               ptr   [CW]   in  - highest-priority index this cycle
//               grant [N_CH] out - one-hot winner, zero when no request
//               idx   [CW]   out - binary index of the winner (0 if none)
//               found        out - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CW   = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   idx,
    output logic            found
);

    // One extra bit so that ptr + k never overflows before the wrap test.
    logic [CW:0]   pos;
    logic [CW-1:0] pos_idx;

    always_comb begin
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = '0;
        pos_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            pos = {1'b0, ptr} + (CW+1)'(k);
            if (pos >= (CW+1)'(N_CH)) begin
                pos = pos - (CW+1)'(N_CH);
            end
            pos_idx = pos[CW-1:0];
            if (!found && req[pos_idx]) begin
                found          = 1'b1;
                grant[pos_idx] = 1'b1;
                idx            = pos_idx;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux
// Description : N_CH-channel round-robin arbiter feeding a single registered
//               output beat (valid/ready on both sides). One beat per cycle
//               throughput when out_ready is held high; an accepted input
//               appears on the output one cycle later. Also registers the OR
//               of all request lines every cycle.
// Options     : RR_ARB_MUX_LOCK_EN - adds in_last[N_CH]; a channel that sends
//               a non-last beat keeps the output until its last beat.
// Ports       : clk        in   rising-edge clock
//               rst_n      in   asynchronous active-low reset
//               in_valid   in   per-channel request/valid [N_CH]
//               in_data    in   channel i at bits [i*DW +: DW]
//               in_last    in   per-channel last-beat flag (option only)
//               in_ready   out  one-hot acceptance, combinational [N_CH]
//               out_valid  out  output register holds a beat
//               out_ready  in   consumer accepts the beat
//               out_data   out  registered winning data [DW]
//               out_ch     out  registered winning channel index [CW]
//               any_req    out  registered OR of in_valid
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int CW   = clog2_min1(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    in_valid,
    input  logic [N_CH*DW-1:0] in_data,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [N_CH-1:0]    in_last,
`endif
    output logic [N_CH-1:0]    in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      out_ch,
    output logic               any_req
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CW-1:0]     ptr;
    logic [CW-1:0]     ptr_nxt;
    logic [N_CH-1:0]   pick_req;
    logic [N_CH-1:0]   grant;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     idx_inc;
    logic              found;
    logic              load;
    logic              xfer;
    logic [DW-1:0]     ch_data [N_CH];

`ifdef RR_ARB_MUX_LOCK_EN
    logic [CW-1:0]     lock_ch;
    logic [CW-1:0]     lock_ch_nxt;
    logic              last_beat;
`endif

    // Split the flat data bus into per-channel words.
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_unpack
            assign ch_data[g] = in_data[g*DW +: DW];
        end
    endgenerate

    // The output register can take a new beat when it is empty or being
    // drained this cycle; this is what allows back-to-back beats.
    assign load = ~out_valid | out_ready;

    // While a packet is locked only the owning channel competes, so the
    // rotating pointer has no influence on the result.
    always_comb begin
        pick_req = in_valid;
`ifdef RR_ARB_MUX_LOCK_EN
        if (state == LOCKED) begin
            pick_req          = '0;
            pick_req[lock_ch] = in_valid[lock_ch];
        end
`endif
    end

    rr_pick #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx),
        .found (found)
    );

    // Gating with rst_n keeps in_ready low for the whole reset period even
    // though the empty output register would otherwise report load=1.
    assign in_ready = grant & {N_CH{load & rst_n}};
    assign xfer     = found & load;
    assign idx_inc  = (idx == CW'(N_CH-1)) ? '0 : idx + CW'(1);

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB;
            ptr     <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_ch <= '0;
`endif
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_ch <= lock_ch_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and pointer update
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
`ifdef RR_ARB_MUX_LOCK_EN
        lock_ch_nxt = lock_ch;
        last_beat   = in_last[idx];
`endif
        case (state)
            ARB: begin
                if (xfer) begin
`ifdef RR_ARB_MUX_LOCK_EN
                    // A single-beat packet behaves like plain arbitration;
                    // otherwise hold the pointer and lock to this channel.
                    if (last_beat) begin
                        ptr_nxt = idx_inc;
                    end else begin
                        state_nxt   = LOCKED;
                        lock_ch_nxt = idx;
                    end
`else
                    ptr_nxt = idx_inc;
`endif
                end
            end
            LOCKED: begin
`ifdef RR_ARB_MUX_LOCK_EN
                // idx equals lock_ch here, so idx_inc is lock_ch+1.
                if (xfer && last_beat) begin
                    state_nxt = ARB;
                    ptr_nxt   = idx_inc;
                end
`else
                state_nxt = ARB;
`endif
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register. When loading with nothing granted the beat is
    // retired but the last data word is deliberately kept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            any_req   <= 1'b0;
        end else begin
            any_req <= |in_valid;
            if (load) begin
                out_valid <= found;
                if (found) begin
                    out_data <= ch_data[idx];
                    out_ch   <= idx;
                end
            end
        end
    end

endmodule : rr_arb_mux
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_mux
// Description : Directed self-checking bench for rr_arb_mux (N_CH=4, DW=8).
//               Channel i carries data i*8'h11. Inputs change 1 time unit
//               after a rising edge; outputs are sampled 1 unit after the
//               edge (registered) or after inputs settle (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux;

    localparam int N_CH = 4;
    localparam int DW   = 8;
    localparam int CW   = 2;

    logic               clk;
    logic               rst_n;
    logic [N_CH-1:0]    in_valid;
    logic [N_CH*DW-1:0] in_data;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [N_CH-1:0]    in_last;
`endif
    logic [N_CH-1:0]    in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic [CW-1:0]      out_ch;
    logic               any_req;

    int total;
    int bad;

    rr_arb_mux #(
        .N_CH (N_CH),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .any_req   (any_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected fairness sequence with all four channels requesting.
    logic [CW-1:0] fair_ch   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [DW-1:0] fair_data [5] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [N_CH-1:0] fair_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
`ifdef RR_ARB_MUX_LOCK_EN
        in_last   = 4'b0000;
`endif
        #2;
        // Reset state; in_ready must stay low despite requests.
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'h00);
        chk("rst_ch",    32'(out_ch),    32'd0);
        chk("rst_anyreq",32'(any_req),   32'd0);
        chk("rst_ready", 32'(in_ready),  32'h0);

        // Release reset; fairness 0,1,2,3,0.
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("fair_ready", 32'(in_ready), 32'(fair_rdy[k]));
            tick();
            chk("fair_valid", 32'(out_valid), 32'd1);
            chk("fair_ch",    32'(out_ch),    32'(fair_ch[k]));
            chk("fair_data",  32'(out_data),  32'(fair_data[k]));
        end
        chk("fair_anyreq", 32'(any_req), 32'd1);

        // Backpressure: output holds ch0 beat, pointer sits at 1.
        out_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data",  32'(out_data),  32'h00);
            chk("bp_ch",    32'(out_ch),    32'd0);
            chk("bp_ready", 32'(in_ready),  32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("bp_rel_ch",   32'(out_ch),   32'd1);
        chk("bp_rel_data", 32'(out_data), 32'h11);
        tick();
        chk("bp_next_ch",   32'(out_ch),   32'd2);
        chk("bp_next_data", 32'(out_data), 32'h22);

        // Sparse with wrap: ptr=3, only ch1 requests.
        in_valid = 4'b0010;
        #1;
        chk("sp_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("sp_ch",   32'(out_ch),   32'd1);
        chk("sp_data", 32'(out_data), 32'h11);
        // Drain with no requests: valid drops, data held.
        in_valid = 4'b0000;
        #1;
        chk("idle_ready", 32'(in_ready), 32'h0);
        tick();
        chk("idle_valid",  32'(out_valid), 32'd0);
        chk("idle_data",   32'(out_data),  32'h11);
        chk("idle_anyreq", 32'(any_req),   32'd0);
        // ptr should now be 2: ch2 beats ch0.
        in_valid = 4'b0101;
        #1;
        chk("ptr2_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("ptr2_ch",     32'(out_ch),  32'd2);
        chk("ptr2_anyreq", 32'(any_req), 32'd1);

        // Single requester ch3 for five cycles.
        in_valid = 4'b1000;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("single_ready", 32'(in_ready), 32'b1000);
            tick();
            chk("single_valid", 32'(out_valid), 32'd1);
            chk("single_ch",    32'(out_ch),    32'd3);
            chk("single_data",  32'(out_data),  32'h33);
        end

        // Asynchronous reset mid-beat.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(out_valid), 32'd0);
        chk("mid_rst_data",   32'(out_data),  32'h00);
        chk("mid_rst_ch",     32'(out_ch),    32'd0);
        chk("mid_rst_anyreq", 32'(any_req),   32'd0);
        in_valid = 4'b1111;
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("post_rst_ch",   32'(out_ch),   32'd0);
        chk("post_rst_data", 32'(out_data), 32'h00);

`ifdef RR_ARB_MUX_LOCK_EN
        // ptr=1; ch2 sends 3 beats (last on third) while ch0 requests.
        in_valid = 4'b0101;
        in_last  = 4'b0000;
        #1;
        chk("lk_ready_a", 32'(in_ready), 32'b0100);
        tick();
        chk("lk_ch_a",    32'(out_ch),   32'd2);
        chk("lk_ready_b", 32'(in_ready), 32'b0100);
        tick();
        chk("lk_ch_b",    32'(out_ch),   32'd2);
        in_last = 4'b0100;
        #1;
        chk("lk_ready_c", 32'(in_ready), 32'b0100);
        tick();
        chk("lk_ch_c",    32'(out_ch),   32'd2);
        chk("lk_ready_d", 32'(in_ready), 32'b0001);
        tick();
        chk("lk_ch_d",    32'(out_ch),   32'd0);
        chk("lk_data_d",  32'(out_data), 32'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        bad++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_rr_arb_mux
`default_nettype wire
